code_stream_decoder: RTL
========================

Name: code_stream_decoder

Overview:
- Receive end of the 8-bit status-code stream produced by the counter/lookup encoder.
- Encoder codes: 0x10/0x20/0x30/0x40 for counter values 0..3; 0x50 for counter values 4..255.
- This block decodes each code back to an index and checks that the code sequence is consistent with a free-running +1 counter that may be reloaded at any time.
- Counts wrap events and errors for the code-coverage / checker infrastructure.

Parameters:
- MAX_DEFAULT_RUN, 252, maximum legal number of consecutive 0x50 samples without a reload (counter values 4..255).
- CNT_W, 16, width of the wrap_cnt and err_cnt counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- code_valid  input  1  code is a valid sample this cycle
- code  input  8  encoded status code
- load_hint  input  1  this sample follows an encoder reload (sel was high the previous cycle); transition check waived
- clr_err  input  1  clears sticky error (used only with the optional feature)
- idx  output  3  decoded index: 0..3, or 4 for 0x50
- idx_valid  output  1  idx holds a legal decoded sample
- illegal  output  1  one-cycle pulse: valid code not in {0x10,0x20,0x30,0x40,0x50}
- seq_err  output  1  sequence violation (see Behaviour)
- wrap_cnt  output  CNT_W  saturating count of 4->0 transitions
- err_cnt  output  CNT_W  saturating count of illegal plus seq_err events
- state  output  2  FSM state: SYNC=0, TRACK=1, ERROR=2

Behaviour:
- Reset: when rst_n=0 at a clk edge, all outputs go to 0, state=SYNC, and the internal prev index and run counter (8 bit) clear.
- Latency: all outputs are registered. A response appears 1 cycle after the sampling edge.
- Decode: 0x10->0, 0x20->1, 0x30->2, 0x40->3, 0x50->4. Any other value is illegal.
- code_valid=0:
  - idx_valid=0 next cycle; idx holds its value.
  - In SYNC or TRACK: state->SYNC (the gap breaks continuity).
  - In ERROR: stay in ERROR.
- Illegal valid code: illegal=1 for 1 cycle, idx_valid=0, err_cnt+1, seq_err not asserted.
  - From SYNC/TRACK: state->SYNC. ERROR stays ERROR.
- SYNC + legal code: idx_valid=1, no sequence check, prev=n, state->TRACK. Run counter = 1 if n=4, else 0.
- TRACK + legal code n (prev p), load_hint=0:
  - p in 0..2: n must equal p+1.
  - p=3: n must equal 4; run becomes 1.
  - p=4, n=4: legal only if run < MAX_DEFAULT_RUN; run+1.
  - p=4, n=0: legal for any run; wrap_cnt+1; run cleared.
  - Anything else is a sequence violation.
- TRACK + load_hint=1: any legal n is accepted. No wrap count, even for 4->0. Run counter = 1 if n=4, else 0.
- Sequence violation: seq_err=1, err_cnt+1, idx_valid=1 (the decode is still reported). prev and run resync to the new sample.
- ERROR state: decoding continues, idx_valid follows legal samples, sequence checking is suspended, illegal still counts.
- Counters saturate at all-ones and never wrap.
- Run counter saturates at 255.
- Simultaneous events:
  - illegal and a gap are exclusive by definition.
  - clr_err together with a new error in the same cycle: the error wins (state stays/enters ERROR).
  - rst_n has priority over everything.

Optional Feature:
- Macro: CODE_STREAM_STICKY_ERR_EN.
- Defined:
  - A sequence violation moves the FSM to ERROR, and seq_err stays 1 while in ERROR.
  - clr_err=1 (with no new error that cycle) -> state=SYNC, seq_err=0 next cycle.
- Undefined:
  - ERROR is unreachable.
  - seq_err is a one-cycle pulse and the FSM stays in TRACK.
  - clr_err is ignored.

Test Plan:
- Reset, then continuous valid codes 0x10,0x20,0x30,0x40, then 252x 0x50, then 0x10 -> idx 0,1,2,3,4..., no errors, wrap_cnt=1, err_cnt=0.
- In TRACK, 0x10 followed by 0x30 with load_hint=0 -> seq_err on the cycle after 0x30, idx=2, err_cnt=1. Repeat with load_hint=1 -> no error.
- 253 consecutive 0x50 after 0x40 -> seq_err on the 253rd sample's response cycle, err_cnt=1.
- code=0x25 mid-stream -> illegal pulse 1 cycle, idx_valid=0, state=SYNC. Next 0x30 is accepted without a check.
- code_valid low for 1 cycle between 0x20 and 0x40 -> state=SYNC, no seq_err.
- CODE_STREAM_STICKY_ERR_EN defined:
  - violation -> seq_err held high for 10 cycles, state=2.
  - clr_err pulse -> seq_err=0, state=0 next cycle.
  - clr_err in the same cycle as a new violation -> stays ERROR.

Source files
------------

// File: rtl/code_stream_decoder_if.sv
// Status-code stream bundle between the encoder side (master) and code_stream_decoder (slave).
// The decoder's results travel back to the master on the same bundle.
interface code_stream_decoder_if #(
    parameter int CNT_W = 16
);
    logic             code_valid;
    logic [7:0]       code;
    logic             load_hint;
    logic             clr_err;
    logic [2:0]       idx;
    logic             idx_valid;
    logic             illegal;
    logic             seq_err;
    logic [CNT_W-1:0] wrap_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       state;

    modport master (
        output code_valid, code, load_hint, clr_err,
        input  idx, idx_valid, illegal, seq_err, wrap_cnt, err_cnt, state
    );

    modport slave (
        input  code_valid, code, load_hint, clr_err,
        output idx, idx_valid, illegal, seq_err, wrap_cnt, err_cnt, state
    );
endinterface

// File: rtl/code_stream_decoder.sv
// Decodes the counter/lookup status-code stream and checks it against a reloadable +1 counter.
// Optional sticky error mode: define CODE_STREAM_STICKY_ERR_EN.
module code_stream_decoder #(
    parameter int MAX_DEFAULT_RUN = 252,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    code_stream_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [7:0] MAX_RUN = 8'(MAX_DEFAULT_RUN);

    state_t           state_reg, state_next;
    logic [2:0]       idx_reg, idx_next;
    logic             idx_valid_reg, idx_valid_next;
    logic             illegal_reg, illegal_next;
    logic             seq_err_reg, seq_err_next;
    logic [CNT_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic [2:0]       prev_reg, prev_next;
    logic [7:0]       run_reg, run_next;

    logic [4:0] hit;
    logic       legal;
    logic [2:0] n_dec;
    logic [7:0] run_inc;
    logic       seq_ok;
    logic       viol;
    logic       new_err;
    logic       wrap_evt;

    // One comparator per legal code; code k+1 in the high nibble decodes to index k.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dec
            assign hit[gi] = (bus.code == 8'((gi + 1) * 16));
        end
    endgenerate

    assign legal   = |hit;
    assign n_dec   = {hit[4], hit[3] | hit[2], hit[3] | hit[1]};
    assign run_inc = (run_reg == 8'hFF) ? run_reg : run_reg + 8'd1;

`ifndef CODE_STREAM_STICKY_ERR_EN
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;
`endif

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        idx_valid_next = 1'b0;
        illegal_next   = 1'b0;
        seq_err_next   = 1'b0;
        prev_next      = prev_reg;
        run_next       = run_reg;
        seq_ok         = 1'b1;
        viol           = 1'b0;
        new_err        = 1'b0;
        wrap_evt       = 1'b0;

        if (!bus.code_valid) begin
            if (state_reg != ERROR) state_next = SYNC;
        end else if (!legal) begin
            illegal_next = 1'b1;
            new_err      = 1'b1;
            if (state_reg != ERROR) state_next = SYNC;
        end else begin
            idx_next       = n_dec;
            idx_valid_next = 1'b1;
            prev_next      = n_dec;
            run_next       = (n_dec == 3'd4) ? 8'd1 : 8'd0;
            case (state_reg)
                SYNC: state_next = TRACK;
                TRACK: begin
                    if (!bus.load_hint) begin
                        if (prev_reg < 3'd3) begin
                            seq_ok = (n_dec == prev_reg + 3'd1);
                        end else if (prev_reg == 3'd3) begin
                            seq_ok = (n_dec == 3'd4);
                        end else if (n_dec == 3'd4) begin
                            seq_ok = (run_reg < MAX_RUN);
                            if (seq_ok) run_next = run_inc;
                        end else begin
                            seq_ok   = (n_dec == 3'd0);
                            wrap_evt = seq_ok;
                        end
                        viol    = !seq_ok;
                        new_err = viol;
                    end
                end
                ERROR: begin
                    // Checking is off here; keep the run length honest anyway.
                    if (n_dec == 3'd4 && prev_reg == 3'd4) run_next = run_inc;
                end
                default: state_next = SYNC;
            endcase
        end

        seq_err_next = viol;
`ifdef CODE_STREAM_STICKY_ERR_EN
        if (viol) begin
            state_next = ERROR;
        end else if (state_reg == ERROR && bus.clr_err && !new_err) begin
            state_next = SYNC;
        end
        if (state_next == ERROR) seq_err_next = 1'b1;
`endif

        wrap_cnt_next = (wrap_evt && wrap_cnt_reg != '1) ? wrap_cnt_reg + CNT_W'(1) : wrap_cnt_reg;
        err_cnt_next  = (new_err && err_cnt_reg != '1) ? err_cnt_reg + CNT_W'(1) : err_cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= SYNC;
            idx_reg       <= '0;
            idx_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            seq_err_reg   <= 1'b0;
            wrap_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            prev_reg      <= '0;
            run_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            idx_valid_reg <= idx_valid_next;
            illegal_reg   <= illegal_next;
            seq_err_reg   <= seq_err_next;
            wrap_cnt_reg  <= wrap_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            prev_reg      <= prev_next;
            run_reg       <= run_next;
        end
    end

    assign bus.idx       = idx_reg;
    assign bus.idx_valid = idx_valid_reg;
    assign bus.illegal   = illegal_reg;
    assign bus.seq_err   = seq_err_reg;
    assign bus.wrap_cnt  = wrap_cnt_reg;
    assign bus.err_cnt   = err_cnt_reg;
    assign bus.state     = state_reg;
endmodule
